// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the SimpleRISC hazard/interlock controller.
// The priority helper is the single place where hazard ordering is decided.
package pipe_ctrl_pkg;

  localparam int REG_AW_DFLT   = 5;
  localparam int MULTI_LAT_MIN = 1;
  localparam int MULTI_LAT_MAX = 16;
  localparam int TMR_W         = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    HZ_NONE   = 2'd0,
    HZ_LU     = 2'd1,
    HZ_MULTI  = 2'd2,
    HZ_BRANCH = 2'd3
  } hazard_e;

  // Branch beats multi-cycle beats load-use.
  function automatic hazard_e hazard_pick(input logic branch,
                                          input logic multi,
                                          input logic lu);
    hazard_e hz;
    hz = HZ_NONE;
    if (branch)     hz = HZ_BRANCH;
    else if (multi) hz = HZ_MULTI;
    else if (lu)    hz = HZ_LU;
    return hz;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_multi_timer.sv
// Loadable down-counter with a terminal-count flag, used to time the BUSY
// sequence of a div/mod occupying the ALU stage.
module hazard_multi_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Drives stall/flush/bubble of the IF/OF, OF/ALU and ALU/MA pipe registers.
// state | meaning
// IDLE  | no sequence running; branch, div start and load-use resolved here
// BUSY  | div/mod occupying ALU; stalls until the timer reaches zero
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULTI_LAT = 4,
  parameter int REG_AW    = REG_AW_DFLT,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_OF,
  input  logic [REG_AW-1:0] rs1_OF,
  input  logic [REG_AW-1:0] rs2_OF,
  input  logic              uses_rs1_OF,
  input  logic              uses_rs2_OF,
  input  logic              is_Ld_ALU,
  input  logic              isWb_ALU,
  input  logic [REG_AW-1:0] rd_ALU,
  input  logic              isMulti_ALU,
  input  logic              isBranchTaken_ALU,
  output logic              stall_IFOF,
  output logic              stall_OFALU,
  output logic              flush_IFOF,
  output logic              flush_OFALU,
  output logic              bubble_ALUMA,
  output logic              busy,
  output logic [CNT_W-1:0]  stall_count
);

  // The first stall cycle is spent in IDLE, so the timer covers the rest.
  localparam bit MULTI_EN = (MULTI_LAT > 1);
  localparam logic [TMR_W-1:0] LOAD_VAL = MULTI_EN ? TMR_W'(MULTI_LAT - 2) : '0;

  state_e  state_q, state_d;
  hazard_e hz;
  logic    lu;
  logic    tmr_load, tmr_dec, tmr_done;
  logic    stall_if, stall_of, flush_if, flush_of, bubble;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign lu = is_Ld_ALU & isWb_ALU & valid_OF &
              ((uses_rs1_OF & (rs1_OF == rd_ALU)) |
               (uses_rs2_OF & (rs2_OF == rd_ALU)));

  assign hz = hazard_pick(isBranchTaken_ALU, isMulti_ALU & MULTI_EN, lu);

  hazard_multi_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (LOAD_VAL),
    .dec_i      (tmr_dec),
    .done_o     (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    stall_if = 1'b0;
    stall_of = 1'b0;
    flush_if = 1'b0;
    flush_of = 1'b0;
    bubble   = 1'b0;
    case (state_q)
      IDLE: begin
        case (hz)
          HZ_BRANCH: begin
            flush_if = 1'b1;
            flush_of = 1'b1;
          end
          HZ_MULTI: begin
            stall_if = 1'b1;
            stall_of = 1'b1;
            bubble   = 1'b1;
            tmr_load = 1'b1;
            state_d  = BUSY;
          end
          HZ_LU: begin
            stall_if = 1'b1;
            flush_of = 1'b1;
          end
          default: ;
        endcase
      end
      BUSY: begin
        if (!tmr_done) begin
          stall_if = 1'b1;
          stall_of = 1'b1;
          bubble   = 1'b1;
          tmr_dec  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Outputs are forced low while reset is held, even with hazards on the inputs.
  assign stall_IFOF   = rst_n & stall_if;
  assign stall_OFALU  = rst_n & stall_of;
  assign flush_IFOF   = rst_n & flush_if;
  assign flush_OFALU  = rst_n & flush_of;
  assign bubble_ALUMA = rst_n & bubble;
  assign busy         = rst_n & (state_q == BUSY);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_IFOF && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with MULTI_LAT=4; outputs are sampled
// on the falling edge, inputs change just after the rising edge.
module tb_pipeline_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              valid_OF = 1'b0;
  logic [REG_AW-1:0] rs1_OF = '0;
  logic [REG_AW-1:0] rs2_OF = '0;
  logic              uses_rs1_OF = 1'b0;
  logic              uses_rs2_OF = 1'b0;
  logic              is_Ld_ALU = 1'b0;
  logic              isWb_ALU = 1'b0;
  logic [REG_AW-1:0] rd_ALU = '0;
  logic              isMulti_ALU = 1'b0;
  logic              isBranchTaken_ALU = 1'b0;
  logic              stall_IFOF, stall_OFALU, flush_IFOF, flush_OFALU, bubble_ALUMA, busy;
  logic [CNT_W-1:0]  stall_count;
  logic [5:0]        outs;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MULTI_LAT(4), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .valid_OF          (valid_OF),
    .rs1_OF            (rs1_OF),
    .rs2_OF            (rs2_OF),
    .uses_rs1_OF       (uses_rs1_OF),
    .uses_rs2_OF       (uses_rs2_OF),
    .is_Ld_ALU         (is_Ld_ALU),
    .isWb_ALU          (isWb_ALU),
    .rd_ALU            (rd_ALU),
    .isMulti_ALU       (isMulti_ALU),
    .isBranchTaken_ALU (isBranchTaken_ALU),
    .stall_IFOF        (stall_IFOF),
    .stall_OFALU       (stall_OFALU),
    .flush_IFOF        (flush_IFOF),
    .flush_OFALU       (flush_OFALU),
    .bubble_ALUMA      (bubble_ALUMA),
    .busy              (busy),
    .stall_count       (stall_count)
  );

  // {stall_IFOF, stall_OFALU, flush_IFOF, flush_OFALU, bubble_ALUMA, busy}
  assign outs = {stall_IFOF, stall_OFALU, flush_IFOF, flush_OFALU, bubble_ALUMA, busy};

  localparam logic [5:0] O_NONE  = 6'b000000;
  localparam logic [5:0] O_LU    = 6'b100100;
  localparam logic [5:0] O_DIV0  = 6'b110010;
  localparam logic [5:0] O_DIVB  = 6'b110011;
  localparam logic [5:0] O_REL   = 6'b000001;
  localparam logic [5:0] O_BR    = 6'b001100;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input string tag, input logic [5:0] exp_o, input int exp_cnt);
    @(negedge clk);
    chk({tag, "_outs"}, 32'(outs), 32'(exp_o));
    chk({tag, "_cnt"}, 32'(stall_count), 32'(exp_cnt));
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    valid_OF = 0; rs1_OF = '0; rs2_OF = '0; uses_rs1_OF = 0; uses_rs2_OF = 0;
    is_Ld_ALU = 0; isWb_ALU = 0; rd_ALU = '0; isMulti_ALU = 0; isBranchTaken_ALU = 0;
  endtask

  task automatic set_ld3_rs1_3();
    is_Ld_ALU = 1; isWb_ALU = 1; rd_ALU = 5'd3;
    valid_OF = 1; rs1_OF = 5'd3; uses_rs1_OF = 1;
  endtask

  // Invariants, checked every cycle outside reset.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("inv_ofalu", 32'(stall_OFALU & flush_OFALU), 32'd0);
      chk("inv_ifof", 32'(stall_IFOF & flush_IFOF), 32'd0);
      chk("inv_busy", 32'(busy), 32'(dut.state_q == BUSY));
      chk("inv_br_div", 32'(isBranchTaken_ALU & isMulti_ALU), 32'd0);
    end
  end

  initial begin
    // Reset: outputs gated low even with a hazard present.
    cyc("rst", O_NONE, 0);
    isBranchTaken_ALU = 1;
    set_ld3_rs1_3();
    cyc("rst_gate", O_NONE, 0);
    clr_inputs();
    @(posedge clk); #1;
    rst_n = 1;

    // Load-use: one bubble, then the load is gone.
    set_ld3_rs1_3();
    cyc("lu", O_LU, 0);
    clr_inputs();
    cyc("lu_after", O_NONE, 1);

    // Near misses and rs2 path.
    set_ld3_rs1_3(); uses_rs1_OF = 0;
    cyc("lu_nouse", O_NONE, 1);
    set_ld3_rs1_3(); rs1_OF = 5'd4;
    cyc("lu_rs4", O_NONE, 1);
    set_ld3_rs1_3(); isWb_ALU = 0;
    cyc("lu_nowb", O_NONE, 1);
    set_ld3_rs1_3(); valid_OF = 0;
    cyc("lu_noval", O_NONE, 1);
    set_ld3_rs1_3(); uses_rs1_OF = 0; rs2_OF = 5'd3; uses_rs2_OF = 1;
    cyc("lu_rs2", O_LU, 1);
    clr_inputs();
    cyc("lu_rs2_after", O_NONE, 2);

    // Single div, MULTI_LAT=4.
    isMulti_ALU = 1;
    cyc("div_s0", O_DIV0, 2);
    cyc("div_s1", O_DIVB, 3);
    cyc("div_s2", O_DIVB, 4);
    cyc("div_rel", O_REL, 5);
    isMulti_ALU = 0;
    cyc("div_done", O_NONE, 5);

    // Branch wins over load-use.
    set_ld3_rs1_3(); isBranchTaken_ALU = 1;
    cyc("br_lu", O_BR, 5);
    clr_inputs();
    cyc("br_after", O_NONE, 5);

    // Back-to-back divs.
    isMulti_ALU = 1;
    cyc("d2_a0", O_DIV0, 5);
    cyc("d2_a1", O_DIVB, 6);
    cyc("d2_a2", O_DIVB, 7);
    cyc("d2_arel", O_REL, 8);
    cyc("d2_b0", O_DIV0, 8);
    cyc("d2_b1", O_DIVB, 9);
    cyc("d2_b2", O_DIVB, 10);
    cyc("d2_brel", O_REL, 11);
    isMulti_ALU = 0;
    cyc("d2_done", O_NONE, 11);

    // Reset while BUSY with cnt=1.
    isMulti_ALU = 1;
    cyc("rb_s0", O_DIV0, 11);
    cyc("rb_s1", O_DIVB, 12);
    rst_n = 0;
    isMulti_ALU = 0;
    cyc("rb_rst", O_NONE, 0);
    rst_n = 1;
    cyc("rb_post0", O_NONE, 0);
    cyc("rb_post1", O_NONE, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard/interlock controller that drives the stall and flush inputs of the inter-stage pipeline registers (IF/OF, OF/ALU, ALU/MA) in the 5-stage SimpleRISC pipeline.
- Detects load-use hazards, multi-cycle ALU operations (div/mod) and taken branches.
- Sequences bubbles and flushes so every pipe register sees a legal stall/flush combination.
- Flush on a pipe register is only honoured when its stall is low, so the block never asserts both on the same register.

Parameters:
MULTI_LAT, 4, total ALU occupancy in cycles of a div/mod instruction; legal range 1..16
REG_AW, 5, register-index width
CNT_W, 16, width of the stall performance counter

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
valid_OF  in  1  OF stage holds a real instruction
rs1_OF  in  REG_AW  first source register read in OF
rs2_OF  in  REG_AW  second source register read in OF
uses_rs1_OF  in  1  OF instruction actually reads rs1_OF
uses_rs2_OF  in  1  OF instruction actually reads rs2_OF
is_Ld_ALU  in  1  ALU stage holds a load
isWb_ALU  in  1  ALU-stage instruction writes back
rd_ALU  in  REG_AW  destination register of the ALU-stage instruction
isMulti_ALU  in  1  ALU stage holds a div/mod
isBranchTaken_ALU  in  1  branch resolved taken in ALU this cycle
stall_IFOF  out  1  hold IF/OF register and PC
stall_OFALU  out  1  hold OF/ALU register
flush_IFOF  out  1  zero IF/OF register
flush_OFALU  out  1  zero OF/ALU register (bubble)
bubble_ALUMA  out  1  force a NOP into ALU/MA register
busy  out  1  state is BUSY
stall_count  out  CNT_W  saturating count of cycles with stall_IFOF=1

Behaviour:
- Clock and reset: one clock `clk`. `rst_n` is asynchronous, active-low.
  - While rst_n=0: state=IDLE, cnt=0, stall_count=0, and all outputs are 0, gated combinationally.
  - Reset mid-BUSY aborts the sequence immediately.
- Registered state: state in {IDLE, BUSY}, cnt[3:0], stall_count. All other outputs are combinational from state, cnt and the current inputs.
- Load-use hazard: lu = is_Ld_ALU & isWb_ALU & valid_OF & ((uses_rs1_OF & rs1_OF==rd_ALU) | (uses_rs2_OF & rs2_OF==rd_ALU)).
- Priority, highest first: reset > isBranchTaken_ALU > multi-cycle > load-use.
- Taken branch (IDLE): flush_IFOF=1 and flush_OFALU=1 for that cycle; all stalls are 0; lu is ignored. Latency 0, with the flush taking effect at the next edge.
- Multi-cycle op:
  - IDLE & isMulti_ALU & MULTI_LAT>1: stall_IFOF=stall_OFALU=bubble_ALUMA=1; at the edge cnt<=MULTI_LAT-2 and state<=BUSY.
  - BUSY & cnt!=0: same three outputs are 1; cnt<=cnt-1.
  - BUSY & cnt==0: all outputs are 0; state<=IDLE and the instruction leaves ALU at this edge.
  - Result: total occupancy is MULTI_LAT cycles with MULTI_LAT-1 stall cycles.
  - A back-to-back div entering ALU on the IDLE cycle restarts the sequence.
  - MULTI_LAT=1: the block never enters BUSY and never stalls for a multi-cycle op.
- Load-use (IDLE, no branch, no multi): stall_IFOF=1, stall_OFALU=0, flush_OFALU=1; one bubble. On the next cycle the load has left ALU, lu=0 and the pipeline proceeds.
- In BUSY, isBranchTaken_ALU and lu are ignored. A div in ALU cannot be a branch or a load; the bench asserts that isBranchTaken_ALU & isMulti_ALU never occurs.
- Invariants, checked by bench assertions:
  - never (stall_OFALU & flush_OFALU);
  - never (stall_IFOF & flush_IFOF);
  - busy == (state==BUSY).
- stall_count: increments on every edge where stall_IFOF=1 and saturates at all-ones.

Decomposition:
- Shared package `pipe_ctrl_pkg`: the state enum {IDLE, BUSY}, REG_AW, the MULTI_LAT range constants, and the hazard priority encoding.
- One natural sub-module, `hazard_multi_timer`: the loadable down-counter with done flag used for the BUSY sequence.
- Load-use compare and output muxing stay in the top module.

Test Plan:
- Load-use: ld r3 in ALU (isWb=1, rd=3), OF reads rs1=3 with uses_rs1=1 -> exactly 1 cycle of stall_IFOF=1, flush_OFALU=1, stall_OFALU=0; stall_count=1.
- Same setup with uses_rs1=0, or with rs1=4 -> no stall and no flush.
- div in ALU, MULTI_LAT=4 -> stall_IFOF=stall_OFALU=bubble_ALUMA=1 for 3 cycles, busy=1 for 3 cycles (the final cycle releases), back to IDLE; stall_count=3.
- Taken branch and lu asserted in the same cycle -> flush_IFOF=flush_OFALU=1 and stall_IFOF=0.
- Two consecutive divs, MULTI_LAT=4 -> 6 stall cycles total with one release cycle between them; stall_count=6.
- rst_n pulled low during BUSY with cnt=1 -> all outputs 0 immediately, state IDLE; after release with no hazards, outputs remain 0.
